wb_arbiter: RTL and testbench

- Sole driver of the register file write port (we/waddr/wdata).
- Merges two result sources:
  - the in-order pipeline writeback, which cannot be stalled in-cycle;
  - a long-latency unit (multi-cycle mul/div, late loads) with valid/ready handshake.
- Late results are buffered in a small FIFO and drained into idle writeback slots.
- Exports a pending-destination mask so decode can interlock RAW/WAW hazards on queued registers.

---
 rtl/wb_arbiter_if.sv | 39 +++
 rtl/wb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Register-file write-port arbitration bus: pipeline writeback, late-unit
// handshake, merged write port and hazard/status outputs.
interface wb_arbiter_if;
  // Pipeline writeback (cannot be stalled in-cycle)
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  // Long-latency unit result handshake
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  // Register-file write port
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  // Hazard and status
  logic [31:0] pend;
  logic        stall_req;
  logic        err;

  // Arbiter view: owns the write port and status outputs
  modport master (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  lu_valid, lu_waddr, lu_wdata,
    output lu_ready,
    output we, waddr, wdata,
    output pend, stall_req, err
  );

  // Environment view: pipeline, late unit and register file
  modport slave (
    output pipe_we, pipe_waddr, pipe_wdata,
    output lu_valid, lu_waddr, lu_wdata,
    input  lu_ready,
    input  we, waddr, wdata,
    input  pend, stall_req, err
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: sole driver of the register-file write port. The
// pipeline writeback has priority; late results wait in a small FIFO and are
// drained into idle slots. A starvation counter raises stall_req so the head
// eventually gets a slot, and pend exposes queued destinations for interlock.
module wb_arbiter #(
  parameter int DEPTH      = 4,  // late-result FIFO entries, power of two >= 2
  parameter int STARVE_MAX = 8   // blocked cycles before stall_req asserts
) (
  input  logic         clk,
  input  logic         rst,      // asynchronous, active-low
  wb_arbiter_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX) + 1;
  localparam logic [STV_W-1:0] STARVE_TOP = STV_W'(STARVE_MAX - 1);

  // FIFO storage and bookkeeping
  logic [4:0]       fifo_addr [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [DEPTH-1:0] slot_vld;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Starvation tracking and status
  logic [STV_W-1:0] starve_cnt;
  logic             stall_q;
  logic             err_q;

  // Registered write port
  logic             we_q;
  logic [4:0]       waddr_q;
  logic [31:0]      wdata_q;

  // Per-cycle decisions
  logic             lu_ready_c;
  logic             pipe_req;
  logic             fifo_nonempty;
  logic             push;
  logic             pop;
  logic             sel_pipe;
  logic             err_set;
  logic             head_blocked;
  logic [31:0]      pend_c;

  // Accept readiness comes from the registered count only, so a same-cycle
  // pop never opens a slot for a same-cycle push.
  assign lu_ready_c    = (count < CNT_W'(DEPTH));
  assign pipe_req      = bus.pipe_we && (bus.pipe_waddr != 5'd0);
  assign fifo_nonempty = (count != '0);
  assign push          = bus.lu_valid && lu_ready_c && (bus.lu_waddr != 5'd0);

  // Pick the write source for this cycle: forced drain, pipeline, then FIFO.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    sel_pipe = 1'b0;
    pop      = 1'b0;
    err_set  = 1'b0;
    if (stall_q && fifo_nonempty) begin
      if (pipe_req) begin
        sel_pipe = 1'b1;  // pipeline cannot be held off; record the collision
        err_set  = 1'b1;
      end else begin
        pop = 1'b1;
      end
    end else if (pipe_req) begin
      sel_pipe = 1'b1;
    end else if (fifo_nonempty) begin
      pop = 1'b1;
    end
    head_blocked = fifo_nonempty && !pop;
  end

  // Payload write into the FIFO slot at the write pointer.
  // NOTE: payload storage has no reset; slot_vld and count say which slots
  // are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.lu_waddr;
      fifo_data[wr_ptr] <= bus.lu_wdata;
    end
  end

  // FIFO pointers, occupancy and per-slot valid flags. Pointers wrap
  // naturally because DEPTH is a power of two. Push and pop can never target
  // the same slot: that would need the FIFO to be both empty and full.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // here updates from values sampled before the edge.
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      slot_vld <= '0;
    end else begin
      if (push) begin
        wr_ptr           <= wr_ptr + 1'b1;
        slot_vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr           <= rd_ptr + 1'b1;
        slot_vld[rd_ptr] <= 1'b0;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Count consecutive cycles the head is held off and raise stall_req once
  // the limit is reached; sticky err records a pipeline write during a drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (!head_blocked) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_TOP) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      stall_q <= head_blocked && (starve_cnt == STARVE_TOP);
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // Registered write port; address and data hold when nothing is written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
    end else if (sel_pipe) begin
      we_q    <= 1'b1;
      waddr_q <= bus.pipe_waddr;
      wdata_q <= bus.pipe_wdata;
    end else if (pop) begin
      we_q    <= 1'b1;
      waddr_q <= fifo_addr[rd_ptr];
      wdata_q <= fifo_data[rd_ptr];
    end else begin
      we_q    <= 1'b0;
    end
  end

  // Pending mask: OR of one-hot destinations of all live FIFO slots.
  always_comb begin
    pend_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld[i]) begin
        pend_c[fifo_addr[i]] = 1'b1;
      end
    end
  end

  assign bus.lu_ready  = lu_ready_c;
  assign bus.we        = we_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.pend      = pend_c;
  assign bus.stall_req = stall_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: a queue-based reference model predicts every
// register-file write and status output; a negedge monitor compares them.
module tb_wb_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_arbiter_if bus ();

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } entry_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int unsigned due;
  } wr_t;

  // Reference model state
  entry_t      lq[$];     // late results waiting, oldest first
  wr_t         exp_q[$];  // scoreboard: predicted writes with due cycle
  int          m_starve;  // consecutive cycles the head was held off
  bit          m_stall;
  bit          m_err;
  int unsigned cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] model_pend();
    logic [31:0] m;
    m = '0;
    foreach (lq[i]) m[lq[i].a] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    lq.delete();
    exp_q.delete();
    m_starve = 0;
    m_stall  = 1'b0;
    m_err    = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs that the DUT
  // also samples on that edge.
  task automatic model_step();
    bit     pipe_req;
    bit     accept;
    bit     had_entries;
    bit     head_pop;
    entry_t e;
    if (!rst) begin
      cyc++;
      return;
    end
    pipe_req    = bus.pipe_we && (bus.pipe_waddr != 5'd0);
    accept      = bus.lu_valid && (lq.size() < DEPTH);
    had_entries = (lq.size() != 0);
    head_pop    = 1'b0;
    if (m_stall && had_entries) begin
      if (pipe_req) begin
        m_err = 1'b1;
        exp_q.push_back('{bus.pipe_waddr, bus.pipe_wdata, cyc + 1});
      end else begin
        head_pop = 1'b1;
      end
    end else if (pipe_req) begin
      exp_q.push_back('{bus.pipe_waddr, bus.pipe_wdata, cyc + 1});
    end else if (had_entries) begin
      head_pop = 1'b1;
    end
    if (head_pop) begin
      e = lq.pop_front();
      exp_q.push_back('{e.a, e.d, cyc + 1});
    end
    m_starve = (had_entries && !head_pop) ? m_starve + 1 : 0;
    m_stall  = (m_starve >= STARVE_MAX);
    if (accept && bus.lu_waddr != 5'd0) begin
      lq.push_back('{bus.lu_waddr, bus.lu_wdata});
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    bus.pipe_we    = pw;
    bus.pipe_waddr = pa;
    bus.pipe_wdata = pd;
    bus.lu_valid   = lv;
    bus.lu_waddr   = la;
    bus.lu_wdata   = ld;
  endtask

  // Monitor: every falling edge, compare the write port against the
  // scoreboard and the status outputs against the model.
  initial begin
    logic [4:0]  hold_a;
    logic [31:0] hold_d;
    wr_t         w;
    hold_a = 5'd0;
    hold_d = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_a = 5'd0;
        hold_d = 32'd0;
      end
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        w = exp_q.pop_front();
        check("we", 32'(bus.we), 32'd1);
        check("waddr", 32'(bus.waddr), 32'(w.a));
        check("wdata", bus.wdata, w.d);
        hold_a = w.a;
        hold_d = w.d;
      end else begin
        check("we_idle", 32'(bus.we), 32'd0);
        check("waddr_hold", 32'(bus.waddr), 32'(hold_a));
        check("wdata_hold", bus.wdata, hold_d);
      end
      check("pend", bus.pend, model_pend());
      check("lu_ready", 32'(bus.lu_ready), 32'(lq.size() < DEPTH));
      check("stall_req", 32'(bus.stall_req), 32'(m_stall));
      check("err", 32'(bus.err), 32'(m_err));
    end
  end

  // Stimulus
  initial begin
    int          k;
    int          busy_pct;
    logic [4:0]  pa;
    logic [31:0] pend_now;

    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    model_reset();
    #1 rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_pend", bus.pend, 32'd0);
    check("rst_lu_ready", 32'(bus.lu_ready), 32'd1);
    check("rst_stall", 32'(bus.stall_req), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);

    // Pipeline only; address 0 counts as idle
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    step();
    check("pipe_we", 32'(bus.we), 32'd1);
    check("pipe_waddr", 32'(bus.waddr), 32'd5);
    check("pipe_wdata", bus.wdata, 32'h1234);
    drive(1'b1, 5'd0, 32'hdead, 1'b0, 5'd0, 32'd0);
    step();
    check("pipe_r0_we", 32'(bus.we), 32'd0);
    check("pipe_r0_hold", 32'(bus.waddr), 32'd5);

    // Late drain: accept, pend visible, written two edges after accept
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hCAFE);
    step();
    check("late_pend7", bus.pend, 32'h80);
    check("late_we0", 32'(bus.we), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    check("late_we", 32'(bus.we), 32'd1);
    check("late_waddr", 32'(bus.waddr), 32'd7);
    check("late_wdata", bus.wdata, 32'hCAFE);
    check("late_pend_clr", bus.pend, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBEEF);
    step();
    check("lu_r0_pend", bus.pend, 32'd0);
    check("lu_r0_we", 32'(bus.we), 32'd0);

    // Full FIFO behind a busy pipeline, then ordered drain
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, 5'(19 + i), 32'(i), 1'b1, 5'(i), 32'(32'h100 + i));
      step();
    end
    check("full_lu_ready", 32'(bus.lu_ready), 32'd0);
    check("full_pend", bus.pend, 32'h1E);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'(24 + i), 32'(i), 1'b1, 5'd5, 32'h105);
      step();
      check("full_hold_ready", 32'(bus.lu_ready), 32'd0);
      check("full_no_r5", bus.pend & 32'h20, 32'd0);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h105);
    step();
    check("drain_r1", 32'(bus.waddr), 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h105);
    step();
    check("drain_r2", 32'(bus.waddr), 32'd2);
    check("drain_r5_queued", bus.pend & 32'h20, 32'h20);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 3; i <= 5; i++) begin
      step();
      check("drain_order", 32'(bus.waddr), 32'(i));
    end

    // Starvation, pipeline yields after stall_req
    drive(1'b1, 5'd10, 32'hA, 1'b1, 5'd9, 32'h99);
    step();
    drive(1'b1, 5'd10, 32'hA, 1'b0, 5'd0, 32'd0);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.stall_req) begin
        k = i;
        break;
      end
    end
    check("starve_cycles", 32'(k), 32'(STARVE_MAX));
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    check("forced_waddr", 32'(bus.waddr), 32'd9);
    check("forced_wdata", bus.wdata, 32'h99);
    check("forced_stall_clr", 32'(bus.stall_req), 32'd0);
    check("forced_no_err", 32'(bus.err), 32'd0);

    // Starvation, pipeline keeps writing: collision sets err
    drive(1'b1, 5'd12, 32'hC, 1'b1, 5'd11, 32'h1111);
    step();
    drive(1'b1, 5'd12, 32'hC, 1'b0, 5'd0, 32'd0);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.stall_req) begin
        k = i;
        break;
      end
    end
    check("starve_cycles2", 32'(k), 32'(STARVE_MAX));
    drive(1'b1, 5'd13, 32'hD, 1'b0, 5'd0, 32'd0);
    step();
    check("collide_waddr", 32'(bus.waddr), 32'd13);
    check("collide_err", 32'(bus.err), 32'd1);
    check("collide_stall", 32'(bus.stall_req), 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    check("collide_drain", 32'(bus.waddr), 32'd11);
    check("err_sticky", 32'(bus.err), 32'd1);

    // Asynchronous reset mid-cycle with three entries queued
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 5'd14, 32'(i), 1'b1, 5'(i), 32'(i));
      step();
    end
    drive(1'b1, 5'd14, 32'h4, 1'b0, 5'd0, 32'd0);
    step();
    check("pre_rst_pend", bus.pend, 32'h0E);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("arst_pend", bus.pend, 32'd0);
    check("arst_we", 32'(bus.we), 32'd0);
    check("arst_err", 32'(bus.err), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    rst = 1'b1;
    check("arst_lu_ready", 32'(bus.lu_ready), 32'd1);
    step();
    check("arst_idle_we", 32'(bus.we), 32'd0);

    // Randomized traffic with varying pipeline load
    busy_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) busy_pct = int'($urandom_range(20, 97));
      pa       = 5'($urandom_range(0, 31));
      pend_now = model_pend();
      if (pend_now[pa]) pa = 5'd0;  // pipeline never writes a queued register
      bus.pipe_we    = ($urandom_range(0, 99) < busy_pct);
      bus.pipe_waddr = pa;
      bus.pipe_wdata = $urandom();
      bus.lu_valid   = ($urandom_range(0, 99) < 40);
      bus.lu_waddr   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.lu_wdata   = $urandom();
      step();
    end

    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (12) step();
    @(negedge clk);
    #1;
    check("final_fifo_empty", 32'(lq.size()), 32'd0);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
